mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 29 ++
 rtl/mem_stage.sv | 143 ++++++++++++++
 tb/tb_mem_stage.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Bus bundle for mem_stage: the pipeline-side load/store handshake and the
// external 16-bit SRAM port. The slave modport is the mem_stage view; the
// master modport is the pipeline plus SRAM side.
interface mem_stage_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] alu_res;
  logic [31:0] val_r_m;
  logic        ready;
  logic [31:0] mem_read_data;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        addr_err;

  modport slave (
    input  mem_r_en, mem_w_en, alu_res, val_r_m, sram_dq_in,
    output ready, mem_read_data, sram_addr, sram_dq_out, sram_dq_oe,
           sram_we_n, addr_err
  );

  modport master (
    output mem_r_en, mem_w_en, alu_res, val_r_m, sram_dq_in,
    input  ready, mem_read_data, sram_addr, sram_dq_out, sram_dq_oe,
           sram_we_n, addr_err
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage of the pipeline. Each 32-bit load/store becomes two 16-bit
// SRAM phases (LO half, then HI half), each SRAM_WAIT cycles long, followed
// by a one-cycle DONE. ready is low for the whole access to freeze the pipe.
// Optional feature: define MEM_STAGE_ADDR_CHECK_EN to reject misaligned or
// out-of-range addresses (access goes straight to DONE with addr_err high).
module mem_stage #(
  parameter int unsigned SRAM_WAIT = 2,
  parameter logic [31:0] DATA_BASE = 32'd1024
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] LAST     = 4'(SRAM_WAIT - 1);
  localparam logic [3:0] PRE_LAST = 4'(SRAM_WAIT - 2);

  state_t      state;
  logic [3:0]  cnt;
  logic        wr;
  logic [16:0] idx;
  logic [31:0] wdata;
  logic [15:0] rd_lo;
  logic [31:0] rd_data_q;
  logic [17:0] addr_q;
  logic [15:0] dq_out_q;
  logic        oe_q;
  logic        we_n_q;

  logic        request;
  logic        last;
  logic [16:0] idx_next;

  assign request  = bus.mem_r_en | bus.mem_w_en;
  assign last     = (cnt == LAST);
  // Word index wraps modulo 2^17 words when the address check is off.
  assign idx_next = 17'((bus.alu_res - DATA_BASE) >> 2);

`ifdef MEM_STAGE_ADDR_CHECK_EN
  logic err_q;
  logic bad;
  // Below base, misaligned, or beyond the 2^17-word SRAM window.
  assign bad = (bus.alu_res < DATA_BASE) || (bus.alu_res[1:0] != 2'b00) ||
               ((bus.alu_res - DATA_BASE) >= 32'h0008_0000);
  assign bus.addr_err = err_q;
`else
  assign bus.addr_err = 1'b0;
`endif

  // ready is combinational only in IDLE so a waiting request stalls at once.
  assign bus.ready         = (state == IDLE) ? ~request : (state == DONE);
  assign bus.mem_read_data = rd_data_q;
  assign bus.sram_addr     = addr_q;
  assign bus.sram_dq_out   = dq_out_q;
  assign bus.sram_dq_oe    = oe_q;
  assign bus.sram_we_n     = we_n_q;

  // Access sequencer with registered SRAM strobes, computed one cycle ahead.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all updates see pre-edge values;
    // a blocking = would let later statements read already-updated state.
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wr        <= 1'b0;
      idx       <= '0;
      wdata     <= '0;
      rd_lo     <= '0;
      rd_data_q <= '0;
      addr_q    <= '0;
      dq_out_q  <= '0;
      oe_q      <= 1'b0;
      we_n_q    <= 1'b1;
`ifdef MEM_STAGE_ADDR_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (request) begin
            // Latch everything now; later input changes are ignored.
            wr    <= bus.mem_w_en;
            idx   <= idx_next;
            wdata <= bus.val_r_m;
            cnt   <= '0;
`ifdef MEM_STAGE_ADDR_CHECK_EN
            if (bad) begin
              state <= DONE;
              err_q <= 1'b1;
            end else
`endif
            begin
              state    <= LO;
              addr_q   <= {idx_next, 1'b0};
              oe_q     <= bus.mem_w_en;
              dq_out_q <= bus.mem_w_en ? bus.val_r_m[15:0] : 16'h0000;
              // First cycle of a phase is never its last (SRAM_WAIT >= 2).
              we_n_q   <= ~bus.mem_w_en;
            end
          end
        end
        LO: begin
          if (last) begin
            rd_lo    <= bus.sram_dq_in;
            state    <= HI;
            cnt      <= '0;
            addr_q   <= {idx, 1'b1};
            dq_out_q <= wr ? wdata[31:16] : 16'h0000;
            we_n_q   <= ~wr;
          end else begin
            cnt    <= cnt + 4'd1;
            // Release the strobe for the final cycle of the phase.
            we_n_q <= ~wr | (cnt == PRE_LAST);
          end
        end
        HI: begin
          if (last) begin
            if (!wr) rd_data_q <= {bus.sram_dq_in, rd_lo};
            state    <= DONE;
            cnt      <= '0;
            addr_q   <= '0;
            dq_out_q <= '0;
            oe_q     <= 1'b0;
            we_n_q   <= 1'b1;
          end else begin
            cnt    <= cnt + 4'd1;
            we_n_q <= ~wr | (cnt == PRE_LAST);
          end
        end
        DONE: begin
          state <= IDLE;
`ifdef MEM_STAGE_ADDR_CHECK_EN
          err_q <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of loads/stores with
// hand-computed read data, plus back-to-back, input-change and mid-access
// reset sequences. A behavioural 256K x 16 SRAM sits on the SRAM port.
module tb_mem_stage;
  localparam int W = 2;

  typedef struct {
    bit          r;
    bit          w;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [15:0] sram [0:262143];
  vec_t vecs [10];

  always #5 clk = ~clk;

  mem_stage_if bus ();

  mem_stage #(.SRAM_WAIT(W), .DATA_BASE(32'd1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.sram_dq_in = sram[bus.sram_addr];
  always @(posedge clk) if (!bus.sram_we_n) sram[bus.sram_addr] <= bus.sram_dq_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_outputs(input string tag);
    check({tag, " sram_addr"}, 32'(bus.sram_addr), 32'h0);
    check({tag, " we_n"}, 32'(bus.sram_we_n), 32'h1);
    check({tag, " dq_oe"}, 32'(bus.sram_dq_oe), 32'h0);
    check({tag, " dq_out"}, 32'(bus.sram_dq_out), 32'h0);
  endtask

  // One access: per-cycle SRAM-port checks, latency, result and return to idle.
  task automatic run_access(input int id, input vec_t v);
    logic [16:0] idx;
    int lat;
    bit ph;
    int pos;
    @(posedge clk); #1;
    bus.mem_r_en = v.r;
    bus.mem_w_en = v.w;
    bus.alu_res  = v.addr;
    bus.val_r_m  = v.data;
    idx = 17'((v.addr - 32'd1024) >> 2);
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.ready) break;
      if (k == 0 || k > 2 * W) begin
        idle_outputs($sformatf("v%0d c%0d", id, k));
      end else begin
        ph  = (k > W);
        pos = ph ? k - W - 1 : k - 1;
        check($sformatf("v%0d c%0d sram_addr", id, k), 32'(bus.sram_addr), 32'({idx, ph}));
        check($sformatf("v%0d c%0d we_n", id, k), 32'(bus.sram_we_n),
              32'(!v.w || (pos == W - 1)));
        check($sformatf("v%0d c%0d dq_oe", id, k), 32'(bus.sram_dq_oe), 32'(v.w));
        check($sformatf("v%0d c%0d dq_out", id, k), 32'(bus.sram_dq_out),
              v.w ? 32'(ph ? v.data[31:16] : v.data[15:0]) : 32'h0);
      end
      lat++;
    end
    check($sformatf("v%0d ready-low cycles", id), lat, v.exp_err ? 1 : 2 * W + 1);
    check($sformatf("v%0d read data", id), bus.mem_read_data, v.exp_rd);
    check($sformatf("v%0d addr_err", id), 32'(bus.addr_err), 32'(v.exp_err));
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d idle ready", id), 32'(bus.ready), 32'h1);
    check($sformatf("v%0d idle addr_err", id), 32'(bus.addr_err), 32'h0);
  endtask

  initial begin
    logic [17:0] bb_addr  [12];
    bit          bb_ready [12];
    vec_t        v;
    int          guard;

    for (int i = 0; i < 262144; i++) sram[i] = 16'h0000;

    vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'd1028, 32'h12345678, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'h12345678, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 32'h12345678, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hCAFEF00D, 1'b0};
`ifdef MEM_STAGE_ADDR_CHECK_EN
    vecs[6] = '{1'b1, 1'b0, 32'd1020,   32'h0,        32'hCAFEF00D, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 32'd1026,   32'h0,        32'hCAFEF00D, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 32'd525312, 32'h0BADC0DE, 32'hCAFEF00D, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 32'd1024,   32'h0,        32'hDEADBEEF, 1'b0};
`else
    vecs[6] = '{1'b0, 1'b1, 32'd525312, 32'h0BADC0DE, 32'hCAFEF00D, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 32'd1024,   32'h0,        32'h0BADC0DE, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 32'd1020,   32'h0,        32'h00000000, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 32'd1026,   32'h0,        32'h0BADC0DE, 1'b0};
`endif

    rst = 1'b1;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.alu_res  = 32'h0;
    bus.val_r_m  = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset ready", 32'(bus.ready), 32'h1);
    check("reset read data", bus.mem_read_data, 32'h0);
    check("reset addr_err", 32'(bus.addr_err), 32'h0);
    idle_outputs("reset");

    for (int i = 0; i < 10; i++) run_access(i, vecs[i]);

    // Back-to-back loads: second starts in the IDLE cycle right after DONE.
    bb_addr  = '{18'd0, 18'd2, 18'd2, 18'd3, 18'd3, 18'd0,
                 18'd0, 18'd4, 18'd4, 18'd5, 18'd5, 18'd0};
    bb_ready = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    @(posedge clk); #1;
    bus.mem_r_en = 1'b1;
    bus.alu_res  = 32'd1028;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("b2b c%0d ready", k), 32'(bus.ready), 32'(bb_ready[k]));
      check($sformatf("b2b c%0d sram_addr", k), 32'(bus.sram_addr), 32'(bb_addr[k]));
      if (k == 5) begin
        check("b2b first read", bus.mem_read_data, 32'h12345678);
        bus.alu_res = 32'd1032;
      end
    end
    check("b2b second read", bus.mem_read_data, 32'hCAFEF00D);
    bus.mem_r_en = 1'b0;

    // Inputs changed mid-access must not disturb the latched write.
    @(posedge clk); #1;
    bus.mem_w_en = 1'b1;
    bus.alu_res  = 32'd1036;
    bus.val_r_m  = 32'h11112222;
    @(posedge clk); #1;
    bus.mem_w_en = 1'b0;
    bus.mem_r_en = 1'b1;
    bus.alu_res  = 32'd1040;
    bus.val_r_m  = 32'hFFFFFFFF;
    guard = 0;
    while (!bus.ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("input-change write completes", 32'(guard < 40), 32'h1);
    bus.mem_r_en = 1'b0;
    @(negedge clk);
    v = '{1'b1, 1'b0, 32'd1036, 32'h0, 32'h11112222, 1'b0};
    run_access(20, v);
    v = '{1'b1, 1'b0, 32'd1040, 32'h0, 32'h00000000, 1'b0};
    run_access(21, v);

    // Reset during the second HI cycle of a write.
    @(posedge clk); #1;
    bus.mem_w_en = 1'b1;
    bus.alu_res  = 32'd1044;
    bus.val_r_m  = 32'hAAAA5555;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.mem_w_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid-reset ready", 32'(bus.ready), 32'h1);
    check("mid-reset read data", bus.mem_read_data, 32'h0);
    check("mid-reset addr_err", 32'(bus.addr_err), 32'h0);
    idle_outputs("mid-reset");
    v = '{1'b1, 1'b0, 32'd1028, 32'h0, 32'h12345678, 1'b0};
    run_access(30, v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
